frv_asi_issue: RTL

//  Issue/writeback wrapper directly upstream of frv_asi (AES/SHA2/SHA3 unit).

---
 rtl/frv_asi_issue_if.sv | 56 +++++
 rtl/frv_asi_issue.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/frv_asi_issue_if.sv
// Issue-side bundle for frv_asi_issue: upstream op handshake, frv_asi
// request/response and writeback handshake. The issue wrapper uses the
// slave view; whatever drives ops and models frv_asi/writeback uses master.
interface frv_asi_issue_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 5
);
    // Pipeline control
    logic            flush;

    // Upstream op from execute
    logic            s_valid;
    logic            s_ready;
    logic [OPW-1:0]  s_uop;
    logic [XLEN-1:0] s_rs1;
    logic [XLEN-1:0] s_rs2;
    logic [1:0]      s_shamt;
    logic [4:0]      s_rd;

    // Request/response with frv_asi
    logic            asi_valid;
    logic            asi_flush;
    logic            asi_ready;
    logic [OPW-1:0]  asi_uop;
    logic [XLEN-1:0] asi_rs1;
    logic [XLEN-1:0] asi_rs2;
    logic [1:0]      asi_shamt;
    logic [XLEN-1:0] asi_result;

    // Writeback
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_result;
    logic            wb_error;

    modport slave (
        input  flush,
        input  s_valid, s_uop, s_rs1, s_rs2, s_shamt, s_rd,
        output s_ready,
        output asi_valid, asi_flush, asi_uop, asi_rs1, asi_rs2, asi_shamt,
        input  asi_ready, asi_result,
        output wb_valid, wb_rd, wb_result, wb_error,
        input  wb_ready
    );

    modport master (
        output flush,
        output s_valid, s_uop, s_rs1, s_rs2, s_shamt, s_rd,
        input  s_ready,
        input  asi_valid, asi_flush, asi_uop, asi_rs1, asi_rs2, asi_shamt,
        output asi_ready, asi_result,
        input  wb_valid, wb_rd, wb_result, wb_error,
        output wb_ready
    );
endinterface

// File: rtl/frv_asi_issue.sv
// Issue/writeback wrapper in front of frv_asi. Holds one op's operands
// stable while the unit works, bounds the wait with a timeout, and returns
// the result (or a timeout error) on a writeback handshake. Operand and
// result registers are cleared whenever they are not needed so that secret
// data never lingers or toggles on the idle buses.
module frv_asi_issue #(
    parameter int XLEN       = 32,
    parameter int OPW        = 5,
    parameter int TMO_CYCLES = 16
) (
    input  logic          g_clk,
    input  logic          g_reset,
    frv_asi_issue_if.slave bus
);

    localparam int CW = $clog2(TMO_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [OPW-1:0]  uop_q,       uop_d;
    logic [XLEN-1:0] rs1_q,       rs1_d;
    logic [XLEN-1:0] rs2_q,       rs2_d;
    logic [1:0]      shamt_q,     shamt_d;
    logic [4:0]      rd_q,        rd_d;
    logic [4:0]      wb_rd_q,     wb_rd_d;
    logic [XLEN-1:0] wb_result_q, wb_result_d;
    logic            wb_error_q,  wb_error_d;

    logic accept;
    logic timeout;

    // Handshake qualifiers shared by the next-state and output logic. A
    // result arriving on the last permitted cycle beats the timeout.
    always_comb begin
        accept  = bus.s_valid && !bus.flush &&
                  ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.wb_ready));
        timeout = (state_q == ST_BUSY) && (cnt_q == CNT_LAST) && !bus.asi_ready;
    end

    // State and datapath registers; reset returns straight to IDLE with
    // everything cleared, so no abort pulse is generated on reset.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            uop_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            shamt_q     <= '0;
            rd_q        <= '0;
            wb_rd_q     <= '0;
            wb_result_q <= '0;
            wb_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            uop_q       <= uop_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            shamt_q     <= shamt_d;
            rd_q        <= rd_d;
            wb_rd_q     <= wb_rd_d;
            wb_result_q <= wb_result_d;
            wb_error_q  <= wb_error_d;
        end
    end

    // Next state and next register contents; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        uop_d       = uop_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        shamt_d     = shamt_q;
        rd_d        = rd_q;
        wb_rd_d     = wb_rd_q;
        wb_result_d = wb_result_q;
        wb_error_d  = wb_error_q;

        if (bus.flush) begin
            // Kill the op and any pending writeback; a same-cycle result is dropped.
            state_d     = ST_IDLE;
            cnt_d       = '0;
            uop_d       = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            shamt_d     = '0;
            rd_d        = '0;
            wb_rd_d     = '0;
            wb_result_d = '0;
            wb_error_d  = 1'b0;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    if (bus.asi_ready || timeout) begin
                        // Completion or abort: operands are no longer needed.
                        state_d     = ST_DONE;
                        cnt_d       = '0;
                        uop_d       = '0;
                        rs1_d       = '0;
                        rs2_d       = '0;
                        shamt_d     = '0;
                        rd_d        = '0;
                        wb_rd_d     = rd_q;
                        wb_result_d = bus.asi_ready ? bus.asi_result : '0;
                        wb_error_d  = !bus.asi_ready;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.wb_ready) begin
                        // Result handed over; scrub it before going idle.
                        state_d     = ST_IDLE;
                        wb_rd_d     = '0;
                        wb_result_d = '0;
                        wb_error_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // New op from IDLE, or back-to-back from DONE as the result leaves.
            if (accept) begin
                state_d = ST_BUSY;
                cnt_d   = '0;
                uop_d   = bus.s_uop;
                rs1_d   = bus.s_rs1;
                rs2_d   = bus.s_rs2;
                shamt_d = bus.s_shamt;
                rd_d    = bus.s_rd;
            end
        end
    end

    // Outputs: operand buses are forced to zero outside BUSY.
    always_comb begin
        bus.s_ready   = !g_reset && !bus.flush &&
                        ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.wb_ready));
        bus.asi_valid = (state_q == ST_BUSY);
        bus.asi_flush = (state_q == ST_BUSY) && (bus.flush || timeout);
        bus.asi_uop   = (state_q == ST_BUSY) ? uop_q   : '0;
        bus.asi_rs1   = (state_q == ST_BUSY) ? rs1_q   : '0;
        bus.asi_rs2   = (state_q == ST_BUSY) ? rs2_q   : '0;
        bus.asi_shamt = (state_q == ST_BUSY) ? shamt_q : '0;
        bus.wb_valid  = (state_q == ST_DONE);
        bus.wb_rd     = wb_rd_q;
        bus.wb_result = wb_result_q;
        bus.wb_error  = wb_error_q;
    end

endmodule
